mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control unit of the multicycle MIPS datapath; directly upstream of the ALU.
//  Sequences each instruction through fetch/decode/execute/memory/writeback states.
//  Drives the ALU's 3-bit operation code and the operand/result mux selects, register/memory write strobes and PC update.
//  Stalls on a single memory-ready handshake.
// PARAMETERS
//  STATE_W   4   width of state register (12 states used)
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  reset        in   1  synchronous, active-high; forces state to FETCH
//  opcode       in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  zero         in   1  ALU zero flag (ALU_result == 0)
//  mem_ready    in   1  memory completes access this cycle
//  alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  alu_src_a    out  1  0=PC, 1=regA
//  alu_src_b    out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
//  pc_src       out  2  00=ALU_result, 01=ALUOut, 10=jump target
//  pc_en        out  1  PC register load enable
//  ior_d        out  1  memory address select: 0=PC, 1=ALUOut
//  ir_write     out  1  instruction register load
//  mem_write    out  1  memory write strobe
//  reg_write    out  1  register file write strobe
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=read data
//  illegal_op   out  1  one-cycle pulse: unsupported opcode/funct
//  state        out  4  current state, for debug/verification
// BEHAVIOUR
//  - Moore outputs from state; exceptions: pc_en, ir_write gated by mem_ready/zero.
//  - Unlisted outputs are 0 in each state. alu_control defaults to 010 (add).
//  - Reset: state=FETCH whenever reset=1 at a clock edge. Outputs then show FETCH decode.
//    All strobes are 0 while mem_ready=0.
//  - Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
//  - FETCH: ior_d=0, src_a=0, src_b=01, add, pc_src=00.
//    ir_write=pc_en=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
//  - DECODE: src_a=0, src_b=11, add (precomputes branch target). Next state by opcode:
//    lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEXEC, j -> JUMP.
//    Any other opcode: illegal_op=1, -> FETCH.
//  - MEMADR: src_a=1, src_b=10, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
//  - MEMREAD: ior_d=1. Hold until mem_ready, then -> MEMWB.
//  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Then -> FETCH.
//  - MEMWRITE: ior_d=1, mem_write=1 held while waiting. On mem_ready -> FETCH.
//  - EXECUTE: src_a=1, src_b=00, alu_control from funct:
//    100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
//    Legal funct -> ALUWB. Other funct: alu_control=010, illegal_op=1, -> FETCH (no write).
//  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Then -> FETCH.
//  - BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_en=zero. Then -> FETCH.
//  - ADDIEXEC: src_a=1, src_b=10, add. Then -> ADDIWB.
//  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Then -> FETCH.
//  - JUMP: pc_src=10, pc_en=1. Then -> FETCH.
//  - Latency (cycles, mem_ready=1): beq/j 3, R/addi/sw 4, lw 5.
//  - Reset mid-instruction: abandon it; next edge state=FETCH, no partial writeback.
//  - Unused encodings of the state register: illegal_op=1, -> FETCH.
// STRUCTURE
//  - Shared include mips_defs.vh holds opcode/funct constants, ALU codes and state encodings.
//    The ALU uses the same ALU codes.
//  - Sub-module alu_decoder: combinational, maps (alu_op[1:0], funct) -> alu_control.
//    alu_op: 00 add, 01 sub, 10 use funct.
// TESTING
//  - Reset for 2 cycles, then release -> state=FETCH; ir_write=pc_en=1, alu_src_b=01, alu_control=010.
//  - lw (opcode 100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//    reg_write=1 only in MEMWB, with mem_to_reg=1.
//  - sw with mem_ready low 3 cycles in MEMWRITE -> mem_write held 4 cycles; single return to FETCH.
//  - R-type, funct 101010 -> alu_control=111 in EXECUTE; reg_dst=1 in ALUWB.
//    funct 000111 -> illegal_op pulse, no reg_write.
//  - beq with zero=1 -> pc_en=1, pc_src=01 in BRANCH. With zero=0 -> pc_en=0.
//    j -> pc_en=1, pc_src=10.
//  - Assert reset while in MEMREAD -> next state FETCH; mem_write and reg_write never asserted.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, funct codes,
// ALU operation codes (also used by the ALU), mux select encodings, the state
// encoding and the bundled control word driven by the output decode.
package mips_multicycle_ctrl_pkg;

    localparam int STATE_W = 4;

    // Instruction opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instr[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REGB    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Coarse ALU request from the FSM; the decoder refines FUNCT via funct
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Twelve states; encodings 12..15 are unused and recover to FETCH
    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    // Everything the output decode produces except alu_control
    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       ior_d;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    // True for the six opcodes the datapath implements
    function automatic logic is_legal_opcode(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the main control unit (master) and the multicycle
// datapath (slave).
//
// Handshake: mem_ready is the only flow-control signal. While the controller
// sits in FETCH, MEMREAD or MEMWRITE it holds its memory-phase outputs
// (ior_d, mem_write) stable; the access completes on the rising edge where
// mem_ready=1, and the controller advances on that same edge. There is no
// separate request strobe: being in a memory state is the request.
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ior_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ior_d,
               ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_control, alu_src_a, alu_src_b, pc_src, pc_en, ior_d,
               ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
    );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's coarse alu_op and the instruction funct field
// to the 3-bit ALU operation code. funct_legal flags whether funct names a
// supported R-type operation; it is only meaningful when alu_op is FUNCT.
module mips_multicycle_ctrl_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_legal
);

    // Unsupported funct falls back to add so the ALU input is never undefined
    always_comb begin
        alu_control = ALU_ADD;
        funct_legal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                funct_legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_ADD;
                        funct_legal = 1'b0;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control unit of the multicycle MIPS datapath. A twelve-state FSM
// walks each instruction through fetch, decode, execute, memory and
// writeback. Outputs are decoded from the current state; the only
// input-dependent outputs are pc_en/ir_write (gated by mem_ready in FETCH,
// by zero in BRANCH) and illegal_op (opcode in DECODE, funct in EXECUTE).
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus,
    output logic [STATE_W-1:0]    state
);

    state_e  state_q;
    state_e  state_d;
    ctrl_t   ctrl;
    alu_op_e alu_op;
    logic    funct_legal;

    mips_multicycle_ctrl_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (bus.funct),
        .alu_control (bus.alu_control),
        .funct_legal (funct_legal)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory states wait on mem_ready, DECODE dispatches on opcode
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = MEMREAD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = MEMWRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
            EXECUTE:  state_d = funct_legal ? ALUWB : FETCH;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            ADDIEXEC: state_d = ADDIWB;
            ADDIWB:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode: every field starts at 0 and the ALU at add
    always_comb begin
        ctrl   = '0;
        alu_op = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_en     = bus.mem_ready;
            end
            DECODE: begin
                // Branch target PC+4+(imm<<2) is computed here speculatively
                ctrl.alu_src_b  = SRC_B_IMM_SH2;
                ctrl.illegal_op = ~is_legal_opcode(bus.opcode);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            MEMREAD: begin
                ctrl.ior_d = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl.ior_d     = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            EXECUTE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRC_B_REGB;
                alu_op          = ALUOP_FUNCT;
                ctrl.illegal_op = ~funct_legal;
            end
            ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REGB;
                alu_op         = ALUOP_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.pc_en     = bus.zero;
            end
            ADDIEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src = PC_SRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: begin
                ctrl.illegal_op = 1'b1;
            end
        endcase
    end

    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.pc_en      = ctrl.pc_en;
    assign bus.ior_d      = ctrl.ior_d;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.illegal_op = ctrl.illegal_op;
    assign state          = state_q;

endmodule
